add_rs: RTL and testbench

- Reservation station feeding the add/sub/logic/branch-compare functional unit in the Execute stage.
- Buffers up to DEPTH dispatched ops and captures missing source operands by snooping the CDB.
- Selects one operand-complete op when the FU reports ready, then drives the FU operands, ALUop, branch_type, load flag and ROB tag for one cycle.
- Sits between dispatch/rename (upstream) and the add FU (downstream).

---
 rtl/add_rs_pkg.sv | 56 +++++
 rtl/add_rs_select.sv | 49 ++++
 rtl/add_rs.sv | 183 ++++++++++++++++++
 tb/tb_add_rs.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add_rs_pkg.sv
// Shared types for the add-unit reservation station: ALU/branch encodings, CDB packet, station entry.
package add_rs_pkg;

    localparam int RS_ROB_W = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } ALU_op_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4,
        BR_LTU  = 3'd5,
        BR_GEU  = 3'd6
    } branch_type_t;

    typedef struct packed {
        logic [RS_ROB_W-1:0] dest_ROB_entry;
        logic [31:0]         result;
        logic                load_step1;
        logic                from_commit;
    } CDB_packet_t;

    typedef struct packed {
        logic                busy;
        ALU_op_t             op;
        branch_type_t        branch;
        logic                load;
        logic [RS_ROB_W-1:0] rob;
        logic                qj_valid;
        logic [RS_ROB_W-1:0] qj;
        logic [31:0]         vj;
        logic                qk_valid;
        logic [RS_ROB_W-1:0] qk;
        logic [31:0]         vk;
    } rs_entry_t;

    // A pending source captures a broadcast only for value-producing packets with its tag.
    function automatic logic cdb_hit(input logic pending, input logic [RS_ROB_W-1:0] tag,
                                     input logic wake, input CDB_packet_t pkt);
        return pending & wake & (tag == pkt.dest_ROB_entry);
    endfunction

endpackage

// File: rtl/add_rs_select.sv
// Issue picker: one-hot grant over ready entries, lowest index first, or oldest first
// when ADD_RS_AGE_ORDER_EN is defined.
module add_rs_select #(
    parameter int DEPTH = 4
`ifdef ADD_RS_AGE_ORDER_EN
  , parameter int AGE_W = 2
`endif
) (
    input  logic [DEPTH-1:0]       req,
`ifdef ADD_RS_AGE_ORDER_EN
    input  logic [DEPTH*AGE_W-1:0] age,
`endif
    output logic [DEPTH-1:0]       grant,
    output logic                   valid
);

`ifdef ADD_RS_AGE_ORDER_EN
    logic [AGE_W-1:0] best;
    logic             found;

    // Ages of busy entries are distinct, so the strict compare never needs a tie-break.
    always_comb begin
        grant = '0;
        best  = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && (!found || age[i*AGE_W +: AGE_W] > best)) begin
                grant    = '0;
                grant[i] = 1'b1;
                best     = age[i*AGE_W +: AGE_W];
                found    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
`endif

    assign valid = |req;

endmodule

// File: rtl/add_rs.sv
// Reservation station for the add/sub/logic/branch-compare FU; snoops the CDB for operands.
// Build option: ADD_RS_AGE_ORDER_EN selects oldest-first issue instead of lowest-index.
module add_rs
    import add_rs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ROB_W = RS_ROB_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  ALU_op_t                      disp_op,
    input  branch_type_t                 disp_branch,
    input  logic                         disp_load,
    input  logic [ROB_W-1:0]             disp_rob,
    input  logic                         disp_qj_valid,
    input  logic                         disp_qk_valid,
    input  logic [ROB_W-1:0]             disp_qj,
    input  logic [ROB_W-1:0]             disp_qk,
    input  logic [31:0]                  disp_vj,
    input  logic [31:0]                  disp_vk,
    input  logic                         cdb_valid,
    input  CDB_packet_t                  cdb,
    input  logic                         fu_ready,
    output logic                         fu_valid,
    output logic [ROB_W-1:0]             fu_rob,
    output logic [31:0]                  fu_rs1,
    output logic [31:0]                  fu_rs2,
    output ALU_op_t                      fu_op,
    output branch_type_t                 fu_branch,
    output logic                         fu_load,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    rs_entry_t        ent [DEPTH];
    rs_entry_t        new_ent;
    rs_entry_t        iss_ent;
    logic [DEPTH-1:0] busy_vec;
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] grant;
    logic             sel_valid;
    logic             issue_fire;
    logic             disp_fire;
    logic             cdb_wake;
    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] iss_idx;
    logic             byp_j;
    logic             byp_k;

    // Commit-sourced broadcasts carry real values and wake like any other.
    logic unused_from_commit;
    assign unused_from_commit = cdb.from_commit;

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_vec[i]  = ent[i].busy;
            ready_vec[i] = ent[i].busy & ~ent[i].qj_valid & ~ent[i].qk_valid;
        end
    end

    assign disp_ready = ~&busy_vec;
    assign cdb_wake   = cdb_valid & ~cdb.load_step1;
    assign disp_fire  = disp_valid & disp_ready & ~flush;
    assign issue_fire = fu_ready & sel_valid;

    always_comb begin
        alloc_idx = '0;
        iss_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_vec[i]) alloc_idx = IDX_W'(i);
            if (grant[i])     iss_idx   = IDX_W'(i);
        end
    end

    assign iss_ent = ent[iss_idx];
    assign byp_j   = cdb_hit(disp_qj_valid, disp_qj, cdb_wake, cdb);
    assign byp_k   = cdb_hit(disp_qk_valid, disp_qk, cdb_wake, cdb);

    always_comb begin
        new_ent          = '0;
        new_ent.busy     = 1'b1;
        new_ent.op       = disp_op;
        new_ent.branch   = disp_branch;
        new_ent.load     = disp_load;
        new_ent.rob      = disp_rob;
        new_ent.qj_valid = disp_qj_valid & ~byp_j;
        new_ent.qj       = disp_qj;
        new_ent.vj       = byp_j ? cdb.result : disp_vj;
        new_ent.qk_valid = disp_qk_valid & ~byp_k;
        new_ent.qk       = disp_qk;
        new_ent.vk       = byp_k ? cdb.result : disp_vk;
    end

`ifdef ADD_RS_AGE_ORDER_EN
    localparam int AGE_W = IDX_W;

    logic [AGE_W-1:0]       age [DEPTH];
    logic [DEPTH*AGE_W-1:0] age_flat;
    logic [AGE_W-1:0]       iss_age;

    always_comb begin
        age_flat = '0;
        for (int i = 0; i < DEPTH; i++) age_flat[i*AGE_W +: AGE_W] = age[i];
    end

    assign iss_age = age[iss_idx];

    // New entry is youngest; entries older than the issued one close the gap it leaves.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire && IDX_W'(i) == alloc_idx) begin
                age[i] <= '0;
            end else if (busy_vec[i]) begin
                if (disp_fire && !(issue_fire && age[i] > iss_age))
                    age[i] <= age[i] + 1'b1;
                else if (!disp_fire && issue_fire && age[i] > iss_age)
                    age[i] <= age[i] - 1'b1;
            end
        end
    end

    add_rs_select #(.DEPTH(DEPTH), .AGE_W(AGE_W)) u_select (
        .req   (ready_vec),
        .age   (age_flat),
        .grant (grant),
        .valid (sel_valid)
    );
`else
    add_rs_select #(.DEPTH(DEPTH)) u_select (
        .req   (ready_vec),
        .grant (grant),
        .valid (sel_valid)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) ent[i].busy <= 1'b0;
            occupancy <= '0;
            fu_valid  <= 1'b0;
            if (reset) begin
                fu_rob    <= '0;
                fu_rs1    <= '0;
                fu_rs2    <= '0;
                fu_op     <= ALU_op_t'('0);
                fu_branch <= branch_type_t'('0);
                fu_load   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent[i].busy && cdb_hit(ent[i].qj_valid, ent[i].qj, cdb_wake, cdb)) begin
                    ent[i].qj_valid <= 1'b0;
                    ent[i].vj       <= cdb.result;
                end
                if (ent[i].busy && cdb_hit(ent[i].qk_valid, ent[i].qk, cdb_wake, cdb)) begin
                    ent[i].qk_valid <= 1'b0;
                    ent[i].vk       <= cdb.result;
                end
            end
            if (issue_fire) ent[iss_idx].busy <= 1'b0;
            if (disp_fire)  ent[alloc_idx]    <= new_ent;

            fu_valid <= issue_fire;
            if (issue_fire) begin
                fu_rob    <= iss_ent.rob;
                fu_rs1    <= iss_ent.vj;
                fu_rs2    <= iss_ent.vk;
                fu_op     <= iss_ent.op;
                fu_branch <= iss_ent.branch;
                fu_load   <= iss_ent.load;
            end
            occupancy <= occupancy + OCC_W'(disp_fire) - OCC_W'(issue_fire);
        end
    end

endmodule

// File: tb/tb_add_rs.sv
// Self-checking bench for add_rs: directed scenarios then random traffic against an op-list model.
module tb_add_rs;
    import add_rs_pkg::*;

    localparam int DEPTH = 4;
    localparam int ROB_W = 4;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               flush = 1'b0;
    logic               disp_valid = 1'b0;
    logic               disp_ready;
    ALU_op_t            disp_op = ALU_ADD;
    branch_type_t       disp_branch = BR_NONE;
    logic               disp_load = 1'b0;
    logic [ROB_W-1:0]   disp_rob = '0;
    logic               disp_qj_valid = 1'b0;
    logic               disp_qk_valid = 1'b0;
    logic [ROB_W-1:0]   disp_qj = '0;
    logic [ROB_W-1:0]   disp_qk = '0;
    logic [31:0]        disp_vj = '0;
    logic [31:0]        disp_vk = '0;
    logic               cdb_valid = 1'b0;
    CDB_packet_t        cdb = '0;
    logic               fu_ready = 1'b0;
    logic               fu_valid;
    logic [ROB_W-1:0]   fu_rob;
    logic [31:0]        fu_rs1;
    logic [31:0]        fu_rs2;
    ALU_op_t            fu_op;
    branch_type_t       fu_branch;
    logic               fu_load;
    logic [OCC_W-1:0]   occupancy;

    add_rs #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_branch(disp_branch), .disp_load(disp_load), .disp_rob(disp_rob),
        .disp_qj_valid(disp_qj_valid), .disp_qk_valid(disp_qk_valid),
        .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_vj(disp_vj), .disp_vk(disp_vk),
        .cdb_valid(cdb_valid), .cdb(cdb), .fu_ready(fu_ready),
        .fu_valid(fu_valid), .fu_rob(fu_rob), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2),
        .fu_op(fu_op), .fu_branch(fu_branch), .fu_load(fu_load), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: ops held in slots with a dispatch sequence number for age ordering.
    bit          m_busy [DEPTH];
    int          m_seq  [DEPTH];
    logic [3:0]  m_op   [DEPTH];
    logic [2:0]  m_br   [DEPTH];
    bit          m_ld   [DEPTH];
    logic [3:0]  m_rob  [DEPTH];
    bit          m_jp   [DEPTH];
    bit          m_kp   [DEPTH];
    logic [3:0]  m_qj   [DEPTH];
    logic [3:0]  m_qk   [DEPTH];
    logic [31:0] m_vj   [DEPTH];
    logic [31:0] m_vk   [DEPTH];
    int          seq_ctr = 0;

    bit          e_valid;
    logic [3:0]  e_rob;
    logic [31:0] e_rs1, e_rs2;
    logic [3:0]  e_op;
    logic [2:0]  e_br;
    bit          e_ld;
    bit          e_fields;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    task automatic model_step();
        int  pick  = -1;
        int  dslot = -1;
        bit  wake  = cdb_valid && !cdb.load_step1;
        e_fields = 1'b0;
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
            e_valid = 0;
            if (reset) begin
                e_rob = 0; e_rs1 = 0; e_rs2 = 0; e_op = 0; e_br = 0; e_ld = 0;
                e_fields = 1'b1;
            end
            return;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (m_busy[i] && !m_jp[i] && !m_kp[i]) begin
`ifdef ADD_RS_AGE_ORDER_EN
                if (pick < 0 || m_seq[i] < m_seq[pick]) pick = i;
`else
                if (pick < 0) pick = i;
`endif
            end
        end
        if (disp_valid && m_count() < DEPTH)
            for (int i = 0; i < DEPTH; i++) if (!m_busy[i] && dslot < 0) dslot = i;
        e_valid = fu_ready && pick >= 0;
        if (e_valid) begin
            e_rob = m_rob[pick]; e_rs1 = m_vj[pick]; e_rs2 = m_vk[pick];
            e_op = m_op[pick]; e_br = m_br[pick]; e_ld = m_ld[pick];
            m_busy[pick] = 0;
            e_fields = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (m_busy[i] && wake && m_jp[i] && m_qj[i] == cdb.dest_ROB_entry) begin
                m_jp[i] = 0; m_vj[i] = cdb.result;
            end
            if (m_busy[i] && wake && m_kp[i] && m_qk[i] == cdb.dest_ROB_entry) begin
                m_kp[i] = 0; m_vk[i] = cdb.result;
            end
        end
        if (dslot >= 0) begin
            m_busy[dslot] = 1; m_seq[dslot] = seq_ctr++;
            m_op[dslot] = disp_op; m_br[dslot] = disp_branch; m_ld[dslot] = disp_load;
            m_rob[dslot] = disp_rob;
            m_jp[dslot] = disp_qj_valid; m_qj[dslot] = disp_qj; m_vj[dslot] = disp_vj;
            m_kp[dslot] = disp_qk_valid; m_qk[dslot] = disp_qk; m_vk[dslot] = disp_vk;
            if (m_jp[dslot] && wake && disp_qj == cdb.dest_ROB_entry) begin
                m_jp[dslot] = 0; m_vj[dslot] = cdb.result;
            end
            if (m_kp[dslot] && wake && disp_qk == cdb.dest_ROB_entry) begin
                m_kp[dslot] = 0; m_vk[dslot] = cdb.result;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("fu_valid", {31'd0, fu_valid}, {31'd0, e_valid});
        chk("occupancy", 32'(occupancy), 32'(m_count()));
        chk("disp_ready", {31'd0, disp_ready}, {31'd0, (m_count() < DEPTH)});
        if (e_fields) begin
            chk("fu_rob", 32'(fu_rob), 32'(e_rob));
            chk("fu_rs1", fu_rs1, e_rs1);
            chk("fu_rs2", fu_rs2, e_rs2);
            chk("fu_op", 32'(fu_op), 32'(e_op));
            chk("fu_branch", 32'(fu_branch), 32'(e_br));
            chk("fu_load", {31'd0, fu_load}, {31'd0, e_ld});
        end
    endtask

    task automatic set_disp(input ALU_op_t op, input logic [3:0] rob,
                            input logic jp, input logic [3:0] qj, input logic [31:0] vj,
                            input logic kp, input logic [3:0] qk, input logic [31:0] vk);
        disp_valid = 1; disp_op = op; disp_branch = BR_NONE; disp_load = 0; disp_rob = rob;
        disp_qj_valid = jp; disp_qj = qj; disp_vj = vj;
        disp_qk_valid = kp; disp_qk = qk; disp_vk = vk;
    endtask

    task automatic set_cdb(input logic v, input logic [3:0] tag, input logic [31:0] res,
                           input logic ls1, input logic fc);
        cdb_valid = v;
        cdb.dest_ROB_entry = tag; cdb.result = res; cdb.load_step1 = ls1; cdb.from_commit = fc;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
        // Reset
        reset = 1; tick(); tick();
        reset = 0;
        // Ready ADD issues the cycle after dispatch
        fu_ready = 1;
        set_disp(ALU_ADD, 4'd3, 0, 0, 32'd5, 0, 0, 32'd7); tick();
        disp_valid = 0; tick();
        chk("add_rob3", 32'(fu_rob), 32'd3);
        chk("add_rs1", fu_rs1, 32'd5);
        chk("add_rs2", fu_rs2, 32'd7);
        // SUB waits for tag 9, issues one cycle after broadcast
        set_disp(ALU_SUB, 4'd5, 1, 4'd9, 32'd0, 0, 0, 32'd2); tick();
        disp_valid = 0; tick();
        set_cdb(1, 4'd9, 32'h10, 0, 0); tick();
        chk("sub_wait", {31'd0, fu_valid}, 32'd0);
        set_cdb(0, 0, 0, 0, 0); tick();
        chk("sub_rs1", fu_rs1, 32'h10);
        // Same-cycle bypass into dispatch
        set_disp(ALU_XOR, 4'd6, 0, 0, 32'h1, 1, 4'd4, 32'd0);
        set_cdb(1, 4'd4, 32'hAA, 0, 0); tick();
        disp_valid = 0; set_cdb(0, 0, 0, 0, 0); tick();
        chk("bypass_rs2", fu_rs2, 32'hAA);
        // Address-step broadcast never wakes; a commit-sourced one does
        set_disp(ALU_OR, 4'd7, 1, 4'd9, 32'd0, 0, 0, 32'd3); tick();
        disp_valid = 0; set_cdb(1, 4'd9, 32'h55, 1, 0); tick();
        set_cdb(0, 0, 0, 0, 0); tick(); tick();
        chk("ls1_nowake_occ", 32'(occupancy), 32'd1);
        set_cdb(1, 4'd9, 32'h77, 0, 1); tick();
        set_cdb(0, 0, 0, 0, 0); tick();
        chk("commit_wake_rs1", fu_rs1, 32'h77);
        // Fill, reject dispatch while full, then drain
        fu_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            set_disp(ALU_AND, 4'(i), 0, 0, 32'(i * 16), 0, 0, 32'(i)); tick();
        end
        chk("full_ready", {31'd0, disp_ready}, 32'd0);
        set_disp(ALU_AND, 4'd9, 0, 0, 0, 0, 0, 0); tick();
        chk("full_occ", 32'(occupancy), 32'd4);
        disp_valid = 0; fu_ready = 1; tick();
        chk("first_issue_rob", 32'(fu_rob), 32'd1);
        chk("drain_ready", {31'd0, disp_ready}, 32'd1);
        tick(); tick(); tick();
        // Flush beats concurrent dispatch
        fu_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_disp(ALU_ADD, 4'(i + 10), 0, 0, 32'd1, 0, 0, 32'd2); tick();
        end
        flush = 1; tick();
        chk("flush_occ", 32'(occupancy), 32'd0);
        flush = 0; disp_valid = 0; fu_ready = 1; tick(); tick();
        // Reset while an issue is on the outputs
        set_disp(ALU_SUB, 4'd2, 0, 0, 32'd9, 0, 0, 32'd8); tick();
        set_disp(ALU_SUB, 4'd3, 0, 0, 32'd9, 0, 0, 32'd8); tick();
        disp_valid = 0;
        chk("pre_reset_valid", {31'd0, fu_valid}, 32'd1);
        reset = 1; tick();
        reset = 0; tick();
        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            flush = ($urandom_range(0, 63) == 0);
            fu_ready = $urandom_range(0, 1);
            disp_valid = ($urandom_range(0, 9) < 6);
            disp_op = ALU_op_t'($urandom_range(0, 9));
            disp_branch = branch_type_t'($urandom_range(0, 6));
            disp_load = $urandom_range(0, 1);
            disp_rob = 4'($urandom_range(0, 15));
            disp_qj_valid = $urandom_range(0, 1);
            disp_qk_valid = $urandom_range(0, 1);
            disp_qj = 4'($urandom_range(8, 11));
            disp_qk = 4'($urandom_range(8, 11));
            disp_vj = $urandom;
            disp_vk = $urandom;
            set_cdb($urandom_range(0, 1), 4'($urandom_range(8, 11)), $urandom,
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
